mem_access_unit: RTL and testbench

Byte-addressed load/store front end between the MEM pipeline stage and the word-addressed `dataMemory` array. It accepts one request at a time over a valid/ready handshake and converts byte addresses to word indices. Byte and halfword stores become read-modify-write sequences. Load data is returned sign- or zero-extended. Misaligned and out-of-range requests are rejected without touching memory.

---
 rtl/mem_access_unit.sv | 137 +++++++++++++
 tb/tb_mem_access_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store front end for a word-addressed data memory.
// Sub-word stores are read-modify-write; loads return sign/zero-extended lanes.
module mem_access_unit #(
  parameter int unsigned ADDR_WORDS = 64
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {StIdle, StRead, StWrite, StResp, StErr} state_e;

  state_e      state_q, state_d;
  logic        write_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rbuf_q;

  logic        accept, req_err;
  logic [31:0] word_idx, merged, load_data;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign accept   = req_valid && (state_q == StIdle);
  assign word_idx = {2'b00, req_addr[31:2]};
  assign req_err  = (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
                    (req_size == 2'b11) ||
                    (word_idx >= 32'(ADDR_WORDS));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q <= req_write;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == StRead) rbuf_q <= mem_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_err)                          state_d = StErr;
          else if (req_write && req_size == 2'b10) state_d = StWrite;
          else                                  state_d = StRead;
        end
      end
      StRead:  state_d = write_q ? StWrite : StResp;
      StWrite: state_d = StResp;
      StResp:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Replace only the addressed lane of the word fetched in READ.
  always_comb begin
    merged = rbuf_q;
    case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  assign byte_v = rbuf_q[{addr_q[1:0], 3'b000} +: 8];
  assign half_v = rbuf_q[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    case (size_q)
      2'b00:   load_data = uns_q ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
      2'b01:   load_data = uns_q ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
      default: load_data = rbuf_q;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    unique case (state_q)
      StIdle: req_ready = 1'b1;
      StRead: begin
        mem_read = 1'b1;
        mem_addr = {2'b00, addr_q[31:2]};
      end
      StWrite: begin
        mem_write = 1'b1;
        mem_addr  = {2'b00, addr_q[31:2]};
        mem_wdata = merged;
      end
      StResp: begin
        resp_valid = 1'b1;
        resp_rdata = write_q ? 32'h0 : load_data;
      end
      StErr: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
      end
      default: req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed requests push expected
// responses; a negedge monitor pops and compares each response.
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  logic [31:0] mem [64];

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          strobe_cnt = 0;
  logic [31:0] last_waddr = '0;

  mem_access_unit #(.ADDR_WORDS(64)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  assign mem_rdata = (mem_read && mem_addr < 32'd64) ? mem[mem_addr[5:0]] : 32'h0;

  always @(negedge CLK) begin
    if (mem_write && mem_addr < 32'd64) mem[mem_addr[5:0]] <= mem_wdata;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: strobe rules plus in-order response comparison with latency.
  always @(negedge CLK) begin
    exp_t e;
    if (mem_read || mem_write) begin
      strobe_cnt++;
      chk("strobe_excl", {31'h0, mem_read & mem_write}, 32'h0);
    end
    if (mem_write) last_waddr = mem_addr;
    if (resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'h1, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end

  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic e, input logic [31:0] er, input int lat);
    int n = 0;
    @(negedge CLK);
    while (!req_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!req_ready) chk("ready_timeout", 32'h0, 32'h1);
    req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge CLK);
    #1;
    sb.push_back('{err: e, rdata: er, lat: lat, acc: cyc});
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'h0);
    @(negedge CLK);
  endtask

  task automatic err_case(input string name, input logic w, input logic [1:0] sz,
                          input logic [31:0] a);
    int s0 = strobe_cnt;
    issue(w, sz, 1'b0, a, 32'h1234_5678, 1'b1, 32'h0, 1);
    drain();
    chk(name, 32'(strobe_cnt - s0), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int busy;
    #2;
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Word store / load
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 2);
    drain();
    chk("sw_waddr", last_waddr, 32'd4);
    chk("sw_mem", mem[4], 32'hDEAD_BEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 2);

    // Byte read-modify-write and byte loads
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 1'b0, 32'h0, 2);
    issue(1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFF_FFAA, 1'b0, 32'h0, 3);
    drain();
    chk("sb_mem", mem[4], 32'h11AA_3344);
    issue(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 1'b0, 32'hFFFF_FFAA, 2);
    issue(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 1'b0, 32'h0000_00AA, 2);
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 32'h0000_0011, 2);

    // Half loads and half store
    issue(1'b1, 2'b10, 1'b0, 32'h14, 32'h8001_7FFF, 1'b0, 32'h0, 2);
    issue(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 1'b0, 32'hFFFF_8001, 2);
    issue(1'b0, 2'b01, 1'b0, 32'h14, 32'h0, 1'b0, 32'h0000_7FFF, 2);
    issue(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 1'b0, 32'h0000_8001, 2);
    issue(1'b1, 2'b01, 1'b0, 32'h16, 32'h0000_BEEF, 1'b0, 32'h0, 3);
    issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b0, 32'hBEEF_7FFF, 2);

    // Last valid word
    issue(1'b1, 2'b10, 1'b0, 32'hFC, 32'hCAFE_F00D, 1'b0, 32'h0, 2);
    issue(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0, 1'b0, 32'hCAFE_F00D, 2);
    drain();

    // Rejected requests
    err_case("err_half_misalign", 1'b0, 2'b01, 32'h13);
    err_case("err_word_misalign", 1'b1, 2'b10, 32'h102);
    err_case("err_out_of_range", 1'b0, 2'b10, 32'h100);
    err_case("err_size11", 1'b0, 2'b11, 32'h20);

    // Held req_valid with changing fields while busy
    issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b0, 32'hBEEF_7FFF, 2);
    req_valid = 1'b1;
    busy = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (req_ready) break;
      busy++;
      req_addr = 32'h100 + 32'(k);
      req_size = 2'(k);
    end
    chk("busy_cycles", 32'(busy), 32'd2);
    req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
    @(posedge CLK);
    #1;
    sb.push_back('{err: 1'b0, rdata: 32'h11AA_3344, lat: 2, acc: cyc});
    req_valid = 1'b0;
    drain();

    // Asynchronous reset in the middle of a load
    @(negedge CLK);
    req_write = 1'b0; req_size = 2'b10; req_addr = 32'h10; req_valid = 1'b1;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    chk("pre_rst_read", {31'h0, mem_read}, 32'h1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("arst_ready", {31'h0, req_ready}, 32'h1);
    chk("arst_mem_read", {31'h0, mem_read}, 32'h0);
    chk("arst_resp_valid", {31'h0, resp_valid}, 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (4) @(negedge CLK);
    issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0, 32'h0000_0033, 2);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
